// File: rtl/udp_rx_if.sv
// Stream interfaces around the UDP receive layer.
//   udp_rx_if  : IP-payload byte stream coming from the IP receiver.
//   udp_rec_if : per-datagram payload stream and status going to the application.

interface udp_rx_if;
  logic [15:0] ip_data_length;
  logic        udp_rx_start;
  logic        udp_rx_valid;
  logic [7:0]  udp_rx_data;
  logic        udp_rx_end;

  modport master (output ip_data_length, udp_rx_start, udp_rx_valid, udp_rx_data, udp_rx_end);
  modport slave  (input  ip_data_length, udp_rx_start, udp_rx_valid, udp_rx_data, udp_rx_end);
endinterface

interface udp_rec_if;
  logic [7:0]  udp_rec_data;
  logic        udp_rec_valid;
  logic        udp_rec_sof;
  logic        udp_rec_eof;
  logic [15:0] udp_rec_src_port;
  logic [15:0] udp_rec_length;
  logic        udp_rec_done;
  logic        udp_rec_drop;
  logic        udp_rec_err;
  logic [1:0]  udp_rec_err_code;

  modport master (output udp_rec_data, udp_rec_valid, udp_rec_sof, udp_rec_eof,
                  udp_rec_src_port, udp_rec_length, udp_rec_done, udp_rec_drop,
                  udp_rec_err, udp_rec_err_code);
  modport slave  (input  udp_rec_data, udp_rec_valid, udp_rec_sof, udp_rec_eof,
                  udp_rec_src_port, udp_rec_length, udp_rec_done, udp_rec_drop,
                  udp_rec_err, udp_rec_err_code);
endinterface

// File: rtl/udp_rx.sv
// UDP receive layer: parses the 8-byte header, filters on destination port,
// forwards payload bytes one cycle after input and drops Ethernet padding.
// Reports source port, payload length and done/drop/error pulses per datagram.

module udp_rx #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'hffff,
  parameter bit          PORT_FILTER    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] local_port,
  udp_rx_if.slave     rx,
  udp_rec_if.master   rec
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    PAD     = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  state_t      state_r, state_s, eff_s;
  logic [15:0] byte_cnt_r, byte_cnt_s, idle_cnt_r, idle_cnt_s, idx_s;
  logic [15:0] ip_len_r, ip_len_s, src_port_r, src_port_s;
  logic [15:0] dst_port_r, dst_port_s, udp_len_r, udp_len_s;
  logic [15:0] out_src_r, out_src_s, out_len_r, out_len_s;
  logic [7:0]  data_r, data_s;
  logic        valid_r, valid_s, sof_r, sof_s, eof_r, eof_s;
  logic        done_r, done_s, drop_r, drop_s, err_r, err_s, abort_s;
  logic [1:0]  code_r, code_s;

  // Next-state, header capture and registered-output decode for the current byte.
  always_comb begin
    state_s    = state_r;
    byte_cnt_s = byte_cnt_r;
    idle_cnt_s = idle_cnt_r;
    ip_len_s   = ip_len_r;
    src_port_s = src_port_r;
    dst_port_s = dst_port_r;
    udp_len_s  = udp_len_r;
    out_src_s  = out_src_r;
    out_len_s  = out_len_r;
    data_s     = data_r;
    code_s     = code_r;
    valid_s    = 1'b0;
    sof_s      = 1'b0;
    eof_s      = 1'b0;
    done_s     = 1'b0;
    drop_s     = 1'b0;
    err_s      = 1'b0;
    abort_s    = 1'b0;
    idx_s      = byte_cnt_r;
    eff_s      = state_r;

    // A start byte always opens a new datagram; any datagram in flight is aborted.
    if (rx.udp_rx_valid && rx.udp_rx_start) begin
      abort_s  = (state_r != IDLE);
      idx_s    = 16'd0;
      eff_s    = HEADER;
      ip_len_s = rx.ip_data_length;
    end else begin
      abort_s  = 1'b0;
    end

    if (!rx.udp_rx_valid) begin
      if (state_r == IDLE) begin
        idle_cnt_s = 16'd0;
      end else if (idle_cnt_r == TIMEOUT_CYCLES - 16'd1) begin
        idle_cnt_s = 16'd0;
        state_s    = IDLE;
        err_s      = 1'b1;
        code_s     = 2'd3;
      end else begin
        idle_cnt_s = idle_cnt_r + 16'd1;
      end
    end else begin
      idle_cnt_s = 16'd0;
      byte_cnt_s = (idx_s == 16'hffff) ? idx_s : idx_s + 16'd1;
      case (eff_s)
        IDLE: begin
          byte_cnt_s = 16'd0;
        end
        HEADER: begin
          state_s = HEADER;
          case (idx_s)
            16'd0:   src_port_s[15:8] = rx.udp_rx_data;
            16'd1:   src_port_s[7:0]  = rx.udp_rx_data;
            16'd2:   dst_port_s[15:8] = rx.udp_rx_data;
            16'd3:   dst_port_s[7:0]  = rx.udp_rx_data;
            16'd4:   udp_len_s[15:8]  = rx.udp_rx_data;
            16'd5:   udp_len_s[7:0]   = rx.udp_rx_data;
            default: ;
          endcase
          if (idx_s == 16'd7) begin
            if ((udp_len_r < 16'd8) || (udp_len_r > ip_len_r)) begin
              err_s   = 1'b1;
              code_s  = 2'd1;
              state_s = rx.udp_rx_end ? IDLE : DRAIN;
            end else if (PORT_FILTER && (dst_port_r != local_port)) begin
              drop_s  = 1'b1;
              state_s = rx.udp_rx_end ? IDLE : DRAIN;
            end else begin
              out_src_s = src_port_r;
              out_len_s = udp_len_r - 16'd8;
              if (udp_len_r == 16'd8) begin
                done_s  = rx.udp_rx_end;
                state_s = rx.udp_rx_end ? IDLE : PAD;
              end else if (rx.udp_rx_end) begin
                err_s   = 1'b1;
                code_s  = 2'd2;
                state_s = IDLE;
              end else begin
                state_s = PAYLOAD;
              end
            end
          end else if (rx.udp_rx_end) begin
            err_s   = 1'b1;
            code_s  = 2'd2;
            state_s = IDLE;
          end else begin
            state_s = HEADER;
          end
        end
        PAYLOAD: begin
          if (idx_s == udp_len_r - 16'd1) begin
            valid_s = 1'b1;
            data_s  = rx.udp_rx_data;
            sof_s   = (idx_s == 16'd8);
            eof_s   = 1'b1;
            done_s  = rx.udp_rx_end;
            state_s = rx.udp_rx_end ? IDLE : PAD;
          end else if (rx.udp_rx_end) begin
            // Truncated datagram: the ending byte is not forwarded and eof is withheld.
            err_s   = 1'b1;
            code_s  = 2'd2;
            state_s = IDLE;
          end else begin
            valid_s = 1'b1;
            data_s  = rx.udp_rx_data;
            sof_s   = (idx_s == 16'd8);
          end
        end
        PAD: begin
          done_s  = rx.udp_rx_end;
          state_s = rx.udp_rx_end ? IDLE : PAD;
        end
        DRAIN: begin
          state_s = rx.udp_rx_end ? IDLE : DRAIN;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
      if (abort_s) begin
        done_s = 1'b0;
        drop_s = 1'b0;
        err_s  = 1'b1;
        code_s = 2'd3;
      end else begin
        code_s = code_s;
      end
    end
  end

  // State, counters, captured header fields and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      byte_cnt_r <= 16'd0;
      idle_cnt_r <= 16'd0;
      ip_len_r   <= 16'd0;
      src_port_r <= 16'd0;
      dst_port_r <= 16'd0;
      udp_len_r  <= 16'd0;
      out_src_r  <= 16'd0;
      out_len_r  <= 16'd0;
      data_r     <= 8'd0;
      valid_r    <= 1'b0;
      sof_r      <= 1'b0;
      eof_r      <= 1'b0;
      done_r     <= 1'b0;
      drop_r     <= 1'b0;
      err_r      <= 1'b0;
      code_r     <= 2'd0;
    end else begin
      state_r    <= state_s;
      byte_cnt_r <= byte_cnt_s;
      idle_cnt_r <= idle_cnt_s;
      ip_len_r   <= ip_len_s;
      src_port_r <= src_port_s;
      dst_port_r <= dst_port_s;
      udp_len_r  <= udp_len_s;
      out_src_r  <= out_src_s;
      out_len_r  <= out_len_s;
      data_r     <= data_s;
      valid_r    <= valid_s;
      sof_r      <= sof_s;
      eof_r      <= eof_s;
      done_r     <= done_s;
      drop_r     <= drop_s;
      err_r      <= err_s;
      code_r     <= code_s;
    end
  end

  assign rec.udp_rec_data     = data_r;
  assign rec.udp_rec_valid    = valid_r;
  assign rec.udp_rec_sof      = sof_r;
  assign rec.udp_rec_eof      = eof_r;
  assign rec.udp_rec_src_port = out_src_r;
  assign rec.udp_rec_length   = out_len_r;
  assign rec.udp_rec_done     = done_r;
  assign rec.udp_rec_drop     = drop_r;
  assign rec.udp_rec_err      = err_r;
  assign rec.udp_rec_err_code = code_r;

endmodule
